// File: rtl/mci_mem_responder.sv
// Responder end of the memory controller interface: a line-wide RAM that serves
// one request at a time and answers after a fixed read or write latency.
package mci_pkg;
    localparam int MCI_ADDR_LENGTH = 32;
    localparam int MCI_DATA_LENGTH = 128;

    typedef struct packed {
        logic [MCI_ADDR_LENGTH-1:0] addr;
        logic [MCI_DATA_LENGTH-1:0] data;
        logic                       rw;
        logic                       valid;
    } mci_request_t;

    typedef struct packed {
        logic [MCI_DATA_LENGTH-1:0] data;
        logic                       ready;
    } mci_response_t;
endpackage

module mci_mem_responder
    import mci_pkg::*;
#(
    parameter int MEM_BLOCKS    = 16384,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  mci_request_t  mem_req,
    output mci_response_t mem_res,
    output logic          busy,
    output logic [15:0]   drop_count
);
    localparam int OFF     = $clog2(MCI_DATA_LENGTH / 8);
    localparam int IDX_W   = $clog2(MEM_BLOCKS);
    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
    typedef logic [IDX_W-1:0]           idx_t;
    typedef logic [CNT_W-1:0]           cnt_t;
    typedef logic [MCI_DATA_LENGTH-1:0] line_t;

    state_e state_q, state_d;
    cnt_t   cnt_q, cnt_d;
    logic   rw_q, rw_d;
    idx_t   idx_q, idx_d;
    line_t  wdata_q, wdata_d;
    line_t  rdata_q;
    logic [15:0] drop_q, drop_d;

    line_t  mem_q [MEM_BLOCKS];

    idx_t   req_idx;
    int     req_lat;
    logic   op_en, op_fire, op_rw;
    idx_t   op_idx;
    line_t  op_wdata;
    logic   unused_addr_bits;

    assign req_idx = mem_req.addr[OFF +: IDX_W];
    assign req_lat = mem_req.rw ? WRITE_LATENCY : READ_LATENCY;
    assign unused_addr_bits = ^{mem_req.addr[MCI_ADDR_LENGTH-1:OFF+IDX_W], mem_req.addr[OFF-1:0]};

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rw_d     = rw_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        drop_d   = drop_q;
        op_en    = 1'b0;
        op_rw    = rw_q;
        op_idx   = idx_q;
        op_wdata = wdata_q;

        case (state_q)
            WAIT: begin
                if (mem_req.valid && drop_q != 16'hFFFF) begin
                    drop_d = drop_q + 16'd1;
                end
                if (cnt_q == '0) begin
                    op_en   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                if (mem_req.valid) begin
                    rw_d    = mem_req.rw;
                    idx_d   = req_idx;
                    wdata_d = mem_req.data;
                    // A single-cycle request operates on the live inputs at the accepting edge.
                    if (req_lat == 1) begin
                        op_en    = 1'b1;
                        op_rw    = mem_req.rw;
                        op_idx   = req_idx;
                        op_wdata = mem_req.data;
                        state_d  = RESP;
                    end else begin
                        cnt_d   = cnt_t'(req_lat - 2);
                        state_d = WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // The RAM port has no reset, so block it explicitly while reset abandons the request.
    assign op_fire = op_en & ~rst;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            drop_q  <= drop_d;
            if (op_fire && !op_rw) begin
                rdata_q <= mem_q[op_idx];
            end
        end
    end

    // NOTE: the RAM array is deliberately not reset so it can map onto block memory.
    always_ff @(posedge clk) begin
        if (op_fire && op_rw) begin
            mem_q[op_idx] <= op_wdata;
        end
    end

    assign mem_res    = '{data: rdata_q, ready: (state_q == RESP)};
    assign busy       = (state_q != IDLE);
    assign drop_count = drop_q;
endmodule

// File: tb/tb_mci_mem_responder.sv
// Bench for mci_mem_responder: an edge-scheduled reference model checked every
// cycle on two instances, plus directed scenarios with literal expectations.
module tb_mci_mem_responder;
    import mci_pkg::*;

    typedef logic [MCI_DATA_LENGTH-1:0] line_t;

    localparam line_t PAT_A5   = 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5;
    localparam line_t PAT_BEEF = 128'hBEEF;
    localparam line_t PAT_1234 = 128'h1234;
    localparam line_t PAT_300  = 128'h300C;
    localparam line_t PAT_40   = 128'h400D;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    mci_request_t  req0, req1;
    mci_response_t res0, res1;
    logic          busy0, busy1;
    logic [15:0]   drop0, drop1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mci_mem_responder #(.MEM_BLOCKS(16384), .READ_LATENCY(4), .WRITE_LATENCY(2)) dut0 (
        .clk(clk), .rst(rst), .mem_req(req0), .mem_res(res0), .busy(busy0), .drop_count(drop0));

    mci_mem_responder #(.MEM_BLOCKS(16), .READ_LATENCY(1), .WRITE_LATENCY(64)) dut1 (
        .clk(clk), .rst(rst), .mem_req(req1), .mem_res(res1), .busy(busy1), .drop_count(drop1));

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: each accepted request is scheduled to complete at edge accept+L-1.
    function automatic int lat_of(input int u, input logic rw);
        if (u == 0) return rw ? 2 : 4;
        return rw ? 64 : 1;
    endfunction

    function automatic int blocks_of(input int u);
        return (u == 0) ? 16384 : 16;
    endfunction

    longint ecount = 0;
    bit     pend [2];
    longint acc_e [2];
    longint resp_e [2];
    bit     m_rw [2];
    int     m_idx [2];
    line_t  m_wd [2];
    bit     e_ready [2];
    bit     e_busy [2];
    line_t  e_data [2];
    bit     e_dknown [2];
    logic [15:0] e_drop [2];
    line_t  mdl_mem [int];

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            pend[u]     = 1'b0;
            e_ready[u]  = 1'b0;
            e_busy[u]   = 1'b0;
            e_data[u]   = '0;
            e_dknown[u] = 1'b1;
            e_drop[u]   = '0;
        end
    endtask

    task automatic model_step(input int u, input mci_request_t r);
        bit fire = 1'b0;
        int key;
        if (pend[u] && ecount > acc_e[u] && ecount <= resp_e[u]) begin
            if (r.valid && e_drop[u] != 16'hFFFF) e_drop[u] = e_drop[u] + 16'd1;
            if (ecount == resp_e[u]) fire = 1'b1;
        end else if (r.valid) begin
            pend[u]   = 1'b1;
            acc_e[u]  = ecount;
            resp_e[u] = ecount + lat_of(u, r.rw) - 1;
            m_rw[u]   = r.rw;
            m_idx[u]  = int'((r.addr >> 4) % blocks_of(u));
            m_wd[u]   = r.data;
            if (resp_e[u] == ecount) fire = 1'b1;
        end
        if (fire) begin
            key = u * 65536 + m_idx[u];
            if (m_rw[u]) begin
                mdl_mem[key] = m_wd[u];
            end else if (mdl_mem.exists(key)) begin
                e_data[u]   = mdl_mem[key];
                e_dknown[u] = 1'b1;
            end else begin
                e_dknown[u] = 1'b0;
            end
        end
        e_ready[u] = fire;
        e_busy[u]  = pend[u] && ecount <= resp_e[u];
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model_reset();
            end else begin
                model_step(0, req0);
                model_step(1, req1);
                ecount++;
            end
        end
    end

    task automatic cmp_unit(input string tag, input int u, input mci_response_t r,
                            input logic b, input logic [15:0] d);
        check($sformatf("%s.ready", tag), r.ready, e_ready[u]);
        check($sformatf("%s.busy", tag), b, e_busy[u]);
        check($sformatf("%s.drop", tag), d, e_drop[u]);
        if (e_dknown[u]) check($sformatf("%s.data", tag), r.data, e_data[u]);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cmp_unit("u0", 0, res0, busy0, drop0);
            cmp_unit("u1", 1, res1, busy1, drop1);
        end
    end

    task automatic tick(input int k = 1);
        repeat (k) @(posedge clk);
        #2;
    endtask

    task automatic send0(input logic rw, input logic [31:0] a, input line_t d);
        req0.valid = 1'b1;
        req0.rw    = rw;
        req0.addr  = a;
        req0.data  = d;
        tick();
        req0.valid = 1'b0;
        req0.addr  = $urandom;
        req0.data  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic send1(input logic rw, input logic [31:0] a, input line_t d);
        req1.valid = 1'b1;
        req1.rw    = rw;
        req1.addr  = a;
        req1.data  = d;
        tick();
        req1.valid = 1'b0;
        req1.addr  = $urandom;
        req1.data  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        req0 = '0;
        req1 = '0;
        #1 rst = 1'b1;
        #1;
        check("reset ready", res0.ready, 1'b0);
        check("reset data", res0.data, 128'h0);
        check("reset busy", busy0, 1'b0);
        check("reset drop", drop0, 16'h0);
        tick(2);
        rst = 1'b0;
        tick();

        // Preload line 5 and read it back through address 0x50.
        send0(1'b1, 32'h50, PAT_A5);
        tick(2);
        send0(1'b0, 32'h50, '0);
        check("rd50 busy first", busy0, 1'b1);
        check("rd50 ready early", res0.ready, 1'b0);
        tick(2);
        check("rd50 ready +3", res0.ready, 1'b0);
        tick();
        check("rd50 ready +4", res0.ready, 1'b1);
        check("rd50 data", res0.data, PAT_A5);
        check("rd50 busy last", busy0, 1'b1);
        tick();
        check("rd50 ready width", res0.ready, 1'b0);
        check("rd50 busy after", busy0, 1'b0);

        // Write latency 2, read-after-write and address aliasing.
        send0(1'b1, 32'h80, PAT_1234);
        check("wr80 ready early", res0.ready, 1'b0);
        tick();
        check("wr80 ready +2", res0.ready, 1'b1);
        check("wr80 data held", res0.data, PAT_A5);
        tick();
        send0(1'b0, 32'h80, '0);
        tick(3);
        check("rd80 data", res0.data, PAT_1234);
        tick();
        send0(1'b0, 32'h80 + 32'(16384 * 16), '0);
        tick(3);
        check("rd80 alias ready", res0.ready, 1'b1);
        check("rd80 alias data", res0.data, PAT_1234);
        tick();

        // Write-back followed by allocate in the write's ready cycle.
        send0(1'b1, 32'h200, PAT_BEEF);
        tick(2);
        send0(1'b1, 32'h100, 128'h100F);
        tick();
        check("wb ready", res0.ready, 1'b1);
        send0(1'b0, 32'h200, '0);
        check("alloc no bubble busy", busy0, 1'b1);
        check("alloc ready low", res0.ready, 1'b0);
        tick(3);
        check("alloc ready", res0.ready, 1'b1);
        check("alloc data", res0.data, PAT_BEEF);
        check("alloc drop", drop0, 16'h0);
        tick();

        // A request arriving mid-flight is dropped and never touches the RAM.
        send0(1'b1, 32'h300, PAT_300);
        tick(2);
        send0(1'b0, 32'h50, '0);
        tick();
        send0(1'b1, 32'h300, 128'hDEAD);
        tick();
        check("drop orig ready", res0.ready, 1'b1);
        check("drop orig data", res0.data, PAT_A5);
        check("drop count 1", drop0, 16'h1);
        tick();
        send0(1'b0, 32'h300, '0);
        tick(3);
        check("drop ram unchanged", res0.data, PAT_300);
        tick();

        // Reset during an in-flight write abandons it.
        send0(1'b1, 32'h40, PAT_40);
        tick(2);
        send0(1'b1, 32'h40, 128'hBAD);
        #1 rst = 1'b1;
        #1;
        check("midrst ready", res0.ready, 1'b0);
        check("midrst data", res0.data, 128'h0);
        check("midrst busy", busy0, 1'b0);
        check("midrst drop", drop0, 16'h0);
        tick();
        check("midrst no ready", res0.ready, 1'b0);
        rst = 1'b0;
        tick(3);
        send0(1'b0, 32'h40, '0);
        tick(3);
        check("midrst old data", res0.data, PAT_40);
        tick();

        // Single-cycle reads back to back, including an aliased address.
        send1(1'b1, 32'h10, 128'h11);
        tick(64);
        send1(1'b1, 32'h20, 128'h22);
        tick(64);
        req1.valid = 1'b1;
        req1.rw    = 1'b0;
        req1.addr  = 32'h10;
        tick();
        check("l1 rd0 ready", res1.ready, 1'b1);
        check("l1 rd0 data", res1.data, 128'h11);
        req1.addr = 32'h20;
        tick();
        check("l1 rd1 ready", res1.ready, 1'b1);
        check("l1 rd1 data", res1.data, 128'h22);
        req1.addr = 32'h110;
        tick();
        check("l1 rd2 alias data", res1.data, 128'h11);
        req1.valid = 1'b0;
        tick();
        check("l1 idle ready", res1.ready, 1'b0);
        check("l1 idle busy", busy1, 1'b0);

        // Hold valid through long writes until the drop counter saturates.
        req1.valid = 1'b1;
        req1.rw    = 1'b1;
        req1.addr  = 32'h30;
        req1.data  = 128'h33;
        tick(66700);
        req1.valid = 1'b0;
        tick(70);
        check("sat drop", drop1, 16'hFFFF);
        check("sat idle", busy1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/mci_mem_responder.md
Name: mci_mem_responder

Overview:
- Responder end of the memory controller interface: accepts `mci_request_t` from a cache and returns `mci_response_t`.
- Backs a block-wide RAM, one `MCI_DATA_LENGTH` line per entry, with configurable read and write latency.
- Serves as the memory model behind the data/instruction caches in simulation, and as a simple on-chip memory in integration.
- One request in flight at a time; requests are matched to responses in order.

Parameters:
- `MEM_BLOCKS`, default 16384: RAM depth in lines. Must be a power of two.
- `READ_LATENCY`, default 4: cycles from the request-sampling edge to the `ready` cycle. Must be ≥1.
- `WRITE_LATENCY`, default 4: same, for writes. Must be ≥1.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous reset, active-high.
- `mem_req`  in  `mci_request_t`  fields: `addr`, `data` (`MCI_DATA_LENGTH`), `rw` (1 = write), `valid`.
- `mem_res`  out  `mci_response_t`  fields: `data` (`MCI_DATA_LENGTH`), `ready`.
- `busy`  out  1  a request is accepted and not yet responded.
- `drop_count`  out  16  number of requests ignored while busy; saturates at 16'hFFFF.

Behaviour:
- Reset: asynchronous, active-high.
  - State goes to IDLE.
  - Outputs: `mem_res.ready`=0, `mem_res.data`=0, `busy`=0, `drop_count`=0.
  - Latched request registers are cleared.
  - RAM contents are not reset.
- Line index = `addr[OFF +: $clog2(MEM_BLOCKS)]`, where `OFF = $clog2(MCI_DATA_LENGTH/8)`.
  - Low `OFF` bits are ignored.
  - Address bits above the index are ignored, so addresses alias modulo `MEM_BLOCKS`.
- Acceptance: a request is sampled at a rising edge where `mem_req.valid`=1 and the state is IDLE or RESP.
  - `addr`, `data` and `rw` are latched at that edge.
  - `valid` is a single-cycle pulse. The requester may change `addr`/`data` afterwards.
- Latency: L = `READ_LATENCY` if `rw`=0, else `WRITE_LATENCY`.
  - Acceptance at edge E0 → `mem_res.ready`=1 for exactly one cycle, the cycle after edge E0+L-1.
  - With L=1, `ready` is high in the cycle right after the request cycle.
- Operation point: the RAM read or write happens at the same edge that raises `ready`.
  - Read: `mem_res.data` = RAM[index], registered, valid only while `ready`=1.
  - Write: RAM[index] ← latched data. `mem_res.data` holds its previous value.
  - A read accepted after a write always returns the written data.
- FSM:
  - IDLE: `valid` → WAIT (L>1) or RESP (L=1).
  - WAIT: down-counter runs; reaching the terminal count → RESP.
  - RESP: `ready`=1. If `valid`, accept the new request and go to WAIT or RESP per its L; otherwise → IDLE.
  - Counter width: `$clog2(max(READ_LATENCY, WRITE_LATENCY)+1)`.
- Back-to-back: a request presented in the RESP cycle is accepted with no bubble.
  - This is the cache write-back→allocate pattern.
  - Back-to-back L=1 requests give `ready` in consecutive cycles.
- `busy`: 1 from the cycle after acceptance until the `ready` cycle inclusive.
- Drops: `valid`=1 while in WAIT (or in RESP with a same-cycle... no — RESP always accepts) is ignored.
  - The in-flight request completes unaffected.
  - `drop_count` increments, saturating.
- `rw`=1 on a request never produces read data on `mem_res.data`.
- Reset mid-operation: the in-flight request is abandoned.
  - `ready` is never raised for it.
  - An unperformed write does not modify the RAM.

Test Plan:
- Reset, `READ_LATENCY`=4: assert `rst` asynchronously mid-cycle → `ready`=0, `data`=0, `busy`=0, `drop_count`=0 immediately, before the next edge.
- Preload RAM[5]=128'hA5…; read at addr 0x50 → `ready` pulses exactly 4 cycles after the sampling edge with data 128'hA5…, one cycle wide; `busy` high 4 cycles.
- Write 128'h1234 to 0x80 (`WRITE_LATENCY`=2), then read 0x80 → write `ready` at +2; read returns 128'h1234; read at 0x80 + `MEM_BLOCKS`*16 also returns 128'h1234 (alias).
- Write-back then allocate: write to 0x100; in its `ready` cycle present a read of 0x200 (preloaded 128'hBEEF) → read accepted with no idle cycle; `ready` after `READ_LATENCY`; data 128'hBEEF; `drop_count`=0.
- Read in flight with `READ_LATENCY`=4; pulse `valid` with a write to 0x300 at cycle +2 → original read completes normally; RAM[0x30] unchanged; `drop_count`=1; 65536 drops leave `drop_count`=16'hFFFF.
- Write to 0x40 in flight; assert `rst` before `ready` → no `ready` pulse; a subsequent read of 0x40 returns the old contents.
